lfsr_noise_shaper: RTL and testbench
====================================

Name: lfsr_noise_shaper

Overview:
- Downstream consumer of the 32-bit maximal-length LFSR in the waveform generator.
- Converts the uniform pseudo-random words into approximately Gaussian, zero-mean, signed noise samples by central-limit summation. Each LFSR word is split into two 16-bit halves and summed over N_WORDS words.
- Applies programmable attenuation and saturation.
- Delivers one sample at a time over a valid/ready interface to the waveform mixer/DAC path.
- Drives the LFSR enable, so the LFSR advances only when a word is consumed.

Parameters:
- N_WORDS, 4: LFSR words per output sample. Power of 2, range 1..16.
- OUT_W, 16: signed output width, range 8..16.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; start and keep producing samples
- atten  input  4  extra arithmetic right shift (0..15), captured in FINAL
- lfsr_word  input  32  current LFSR output, consumed in the cycle lfsr_en=1
- lfsr_en  output  1  LFSR advance request, one pulse per word consumed
- noise_data  output  OUT_W  signed noise sample, two's complement
- noise_valid  output  1  sample available
- noise_ready  input  1  downstream accepts when valid&ready
- busy  output  1  high in ACCUM and FINAL

Behaviour:
- Reset values (asynchronous, active-high; clock clk): state=IDLE, accumulator=0, word counter=0, lfsr_en=0, noise_data=0, noise_valid=0, busy=0.
- Constants:
  - SUM_W = 17 + log2(N_WORDS) + 1 (unsigned sum plus sign bit).
  - MEAN = N_WORDS*65535.
  - BASE_SH = log2(N_WORDS) + 1 + (16 - OUT_W).
- FSM states:
  - IDLE: lfsr_en=0. Go to ACCUM when run=1.
  - ACCUM:
    - lfsr_en=1 every cycle.
    - acc <= acc + lfsr_word[31:16] + lfsr_word[15:0]. On the first ACCUM cycle, acc is loaded rather than added.
    - Counter runs 0..N_WORDS-1. At N_WORDS-1, go to FINAL.
    - Exactly N_WORDS lfsr_en pulses per sample.
  - FINAL:
    - lfsr_en=0.
    - centered = signed(acc) - MEAN.
    - shifted = centered >>> (BASE_SH + atten), arithmetic, floor rounding.
    - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Register into noise_data and set noise_valid=1. Go to HOLD.
  - HOLD:
    - noise_data and noise_valid are held stable while noise_ready=0; lfsr_en=0.
    - On noise_valid&noise_ready: noise_valid drops next cycle, unless a new sample is being issued. Next state is ACCUM if run=1, else IDLE.
- Latency: the first noise_valid is asserted N_WORDS+1 cycles after the cycle in which ACCUM is entered.
- Steady-state throughput with ready tied high: one sample per N_WORDS+2 cycles. This covers N_WORDS ACCUM cycles, 1 FINAL cycle and 1 HOLD/handshake cycle.
- run deasserted during ACCUM or FINAL: the current sample completes and is delivered. IDLE is entered after the handshake.
- atten is sampled only in FINAL. Changes during ACCUM do not affect the in-flight sample.
- Reset asserted mid-operation: immediate return to reset values. Partially accumulated data is discarded and no spurious valid is produced.
- Accumulator never overflows (SUM_W sized for the worst case, all halves 0xFFFF).
- Saturation is only reachable in the negative direction at atten=0, for all-zero words: -MEAN>>>BASE_SH = -2^(OUT_W-1) exactly. It must clip correctly for any OUT_W.

Decomposition:
- Shared package noise_pkg holds:
  - the FSM state enum (IDLE, ACCUM, FINAL, HOLD);
  - functions for SUM_W, MEAN and BASE_SH;
  - the saturation helper function.
- One natural sub-module: noise_sat_shift. It is combinational-only; it takes centered, atten and BASE_SH and produces the saturated OUT_W result. It is reused by the planned filtered-noise path.

Test Plan:
- N_WORDS=4, OUT_W=16, atten=0, lfsr_word held 0xFFFFFFFF, run=1, ready=1 -> exactly 4 lfsr_en pulses per sample; noise_data=32767; first valid 5 cycles after ACCUM entry.
- Same config, lfsr_word=0x00000000 -> noise_data=-32768 (0x8000). With atten=1: 0xFFFFFFFF gives 16383, 0x00000000 gives -16384.
- lfsr_word=0x80007FFF for every word -> noise_data=0 on every sample. Throughput is one sample per 6 cycles with ready=1.
- Backpressure: hold noise_ready=0 for 10 cycles after valid -> noise_data and noise_valid stable, lfsr_en=0 throughout. Releasing ready produces exactly one handshake, then ACCUM resumes.
- Drop run in the 2nd ACCUM cycle -> the sample still completes with 4 lfsr_en pulses, is delivered, and the FSM returns to IDLE with no further lfsr_en.
- Assert reset in the 3rd ACCUM cycle -> all outputs 0 asynchronously. After release with run=1, the next sample again uses exactly 4 fresh words and the value matches the reference model.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared types and constant helpers for the LFSR noise shaper and the
// filtered-noise path that will reuse its saturation/shift stage.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    HOLD
  } state_t;

  // Width of the unsigned sum of 2*n_words 16-bit halves, plus a sign bit.
  function automatic int calc_sum_w(input int n_words);
    return 17 + $clog2(n_words) + 1;
  endfunction

  function automatic int calc_mean(input int n_words);
    return n_words * 65535;
  endfunction

  function automatic int calc_base_sh(input int n_words, input int out_w);
    return $clog2(n_words) + 1 + (16 - out_w);
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/noise_sat_shift.sv
// Combinational attenuation (arithmetic floor shift) and saturation of a
// zero-centered sum down to an OUT_W-bit two's complement sample.
module noise_sat_shift
  import noise_pkg::*;
#(
  parameter int SUM_W   = 20,
  parameter int OUT_W   = 16,
  parameter int BASE_SH = 3
) (
  input  logic signed [SUM_W-1:0] centered,
  input  logic        [3:0]       atten,
  output logic signed [OUT_W-1:0] result
);

  logic        [5:0]  shift_amt;
  logic signed [31:0] wide;
  logic signed [31:0] shifted;

  // Sign-extend first so shifts beyond SUM_W still fill with the sign bit.
  assign wide      = {{(32 - SUM_W){centered[SUM_W-1]}}, centered};
  assign shift_amt = 6'(BASE_SH) + {2'b00, atten};
  assign shifted   = wide >>> shift_amt;
  assign result    = OUT_W'(saturate(shifted, OUT_W));

endmodule

// File: rtl/lfsr_noise_shaper.sv
// Central-limit noise shaper: sums 2*N_WORDS LFSR half-words, removes the
// mean, attenuates/saturates and hands samples out over valid/ready.
module lfsr_noise_shaper
  import noise_pkg::*;
#(
  parameter int N_WORDS = 4,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic        [3:0]       atten,
  input  logic        [31:0]      lfsr_word,
  output logic                    lfsr_en,
  output logic signed [OUT_W-1:0] noise_data,
  output logic                    noise_valid,
  input  logic                    noise_ready,
  output logic                    busy
);

  localparam int SUM_W   = calc_sum_w(N_WORDS);
  localparam int BASE_SH = calc_base_sh(N_WORDS, OUT_W);
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic signed [SUM_W-1:0] MEAN_S = SUM_W'(calc_mean(N_WORDS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  state_t                    state;
  logic        [SUM_W-1:0]   acc;
  logic        [CNT_W-1:0]   word_cnt;
  logic        [16:0]        word_sum;
  logic        [SUM_W-1:0]   word_sum_ext;
  logic signed [SUM_W-1:0]   centered;
  logic signed [OUT_W-1:0]   shaped;

  assign word_sum     = {1'b0, lfsr_word[31:16]} + {1'b0, lfsr_word[15:0]};
  assign word_sum_ext = SUM_W'(word_sum);
  assign centered     = $signed(acc) - MEAN_S;

  noise_sat_shift #(
    .SUM_W  (SUM_W),
    .OUT_W  (OUT_W),
    .BASE_SH(BASE_SH)
  ) u_sat_shift (
    .centered(centered),
    .atten   (atten),
    .result  (shaped)
  );

  // lfsr_en and busy are registered alongside the state so they are high
  // exactly while the FSM sits in ACCUM (and FINAL for busy).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      word_cnt    <= '0;
      lfsr_en     <= 1'b0;
      noise_data  <= '0;
      noise_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= ACCUM;
            word_cnt <= '0;
            lfsr_en  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= (word_cnt == '0) ? word_sum_ext : acc + word_sum_ext;
          if (word_cnt == LAST_CNT) begin
            state    <= FINAL;
            word_cnt <= '0;
            lfsr_en  <= 1'b0;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        FINAL: begin
          noise_data  <= shaped;
          noise_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= HOLD;
        end
        HOLD: begin
          if (noise_ready) begin
            noise_valid <= 1'b0;
            if (run) begin
              state    <= ACCUM;
              word_cnt <= '0;
              lfsr_en  <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          lfsr_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_noise_shaper.sv
// Scoreboard bench for lfsr_noise_shaper (N_WORDS=4, OUT_W=16) driven by
// directed word patterns with hand-computed expected samples.
module tb_lfsr_noise_shaper;

  localparam int N_WORDS = 4;
  localparam int OUT_W   = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    run = 1'b0;
  logic        [3:0]       atten = 4'd0;
  logic        [31:0]      lfsr_word = 32'h0;
  logic                    lfsr_en;
  logic signed [OUT_W-1:0] noise_data;
  logic                    noise_valid;
  logic                    noise_ready = 1'b1;
  logic                    busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  int pulses = 0;
  int exp_q[$];
  int hs_cycle[$];

  logic        use_table = 1'b0;
  logic [1:0]  tidx;
  logic [31:0] tbl [4] = '{32'h12345678, 32'hFFFF0000, 32'h00010002, 32'hABCD1234};

  lfsr_noise_shaper #(.N_WORDS(N_WORDS), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .atten      (atten),
    .lfsr_word  (lfsr_word),
    .lfsr_en    (lfsr_en),
    .noise_data (noise_data),
    .noise_valid(noise_valid),
    .noise_ready(noise_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Table index models a fresh LFSR that advances once per consumed word.
  always @(posedge clk or posedge reset) begin
    if (reset) tidx <= 2'd0;
    else if (lfsr_en && tidx != 2'd3) tidx <= tidx + 2'd1;
  end

  always @(negedge clk) if (use_table) lfsr_word = tbl[tidx];

  function automatic void check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // Monitor: pops the scoreboard on every handshake and audits word usage.
  always @(negedge clk) begin
    if (reset) begin
      pulses = 0;
    end else begin
      if (lfsr_en) pulses++;
      if (noise_valid && noise_ready) begin
        hs_cycle.push_back(cyc);
        hs_count++;
        if (exp_q.size() == 0) check_output("unexpected_sample", 1, 0);
        else check_output("noise_data", int'(noise_data), exp_q.pop_front());
        check_output("en_pulses", pulses, N_WORDS);
        pulses = 0;
      end
    end
  end

  task automatic wait_hs(input int target, input string name);
    for (int i = 0; i < 80 && hs_count < target; i++) @(negedge clk);
    check_output(name, (hs_count >= target) ? 1 : 0, 1);
  endtask

  task automatic idle_check(input string name);
    int bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (lfsr_en || busy || noise_valid) bad++;
    end
    check_output(name, bad, 0);
  endtask

  task automatic apply_stimulus(input int n, input logic [31:0] word, input logic [3:0] att,
                                input int expected, input int drop_at);
    int start = hs_count;
    int entry = -1;
    int vt = -1;
    lfsr_word = word;
    atten     = att;
    repeat (n) exp_q.push_back(expected);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lfsr_en) begin
        entry = cyc;
        break;
      end
    end
    check_output("accum_entry", (entry >= 0) ? 1 : 0, 1);
    check_output("busy_in_accum", int'(busy), 1);
    if (n == 1) begin
      repeat (drop_at - 1) @(negedge clk);
      run = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      if (noise_valid) begin
        vt = cyc;
        break;
      end
      @(negedge clk);
    end
    check_output("first_valid_latency", vt - entry, N_WORDS + 1);
    if (n > 1) begin
      wait_hs(start + n - 1, "hs_before_drop");
      @(negedge clk);
      run = 1'b0;
    end
    wait_hs(start + n, "hs_all");
    for (int k = 1; k < n; k++)
      check_output("throughput", hs_cycle[start + k] - hs_cycle[start + k - 1], N_WORDS + 2);
    idle_check("idle_after_run");
    check_output("hs_count", hs_count - start, n);
  endtask

  task automatic backpressure_test();
    int start = hs_count;
    int bad_d = 0;
    int bad_e = 0;
    int vt = -1;
    lfsr_word   = 32'h80007FFF;
    atten       = 4'd0;
    noise_ready = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(0);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (noise_valid) begin
        vt = cyc;
        break;
      end
    end
    check_output("bp_valid_seen", (vt >= 0) ? 1 : 0, 1);
    repeat (10) begin
      @(negedge clk);
      if (!noise_valid || noise_data != 16'sd0) bad_d++;
      if (lfsr_en) bad_e++;
    end
    check_output("bp_data_valid_stable", bad_d, 0);
    check_output("bp_no_lfsr_en", bad_e, 0);
    check_output("bp_no_handshake", hs_count - start, 0);
    @(posedge clk);
    #1 noise_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_accum_resumed", int'(lfsr_en), 1);
    check_output("bp_single_handshake", hs_count - start, 1);
    run = 1'b0;
    wait_hs(start + 2, "bp_second_sample");
    idle_check("bp_idle_after");
  endtask

  task automatic reset_test();
    int start;
    int entry = -1;
    use_table = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lfsr_en) begin
        entry = cyc;
        break;
      end
    end
    check_output("rst_accum_entry", (entry >= 0) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("rst_lfsr_en", int'(lfsr_en), 0);
    check_output("rst_valid", int'(noise_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_data", int'(noise_data), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    start = hs_count;
    // 0x1234+0x5678 + 0xFFFF+0 + 1+2 + 0xABCD+0x1234 = 140975; (140975-262140)>>>3
    exp_q.push_back(-15146);
    entry = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lfsr_en) begin
        entry = cyc;
        break;
      end
    end
    check_output("post_rst_entry", (entry >= 0) ? 1 : 0, 1);
    run = 1'b0;
    wait_hs(start + 1, "post_rst_sample");
    idle_check("post_rst_idle");
    use_table = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_lfsr_en", int'(lfsr_en), 0);
    check_output("reset_valid", int'(noise_valid), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_data", int'(noise_data), 0);
    reset = 1'b0;
    @(negedge clk);

    apply_stimulus(3, 32'hFFFFFFFF, 4'd0, 32767, 1);
    apply_stimulus(1, 32'h00000000, 4'd0, -32768, 1);
    apply_stimulus(2, 32'hFFFFFFFF, 4'd1, 16383, 1);
    apply_stimulus(2, 32'h00000000, 4'd1, -16384, 1);
    apply_stimulus(3, 32'h80007FFF, 4'd0, 0, 1);
    apply_stimulus(1, 32'hFFFFFFFF, 4'd0, 32767, 2);
    backpressure_test();
    reset_test();

    check_output("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
